// File: rtl/cla_result_checker.sv
// Response checker for the 4-bit CLA self-check harness: aligns stimulus with adder responses and compares to a+b+cin.
// Optional macro CHK_HALT_ON_ERR_EN: end the run on the first mismatch.
module cla_result_checker #(
    parameter int WIDTH = 4,
    parameter int DLY   = 0,
    parameter int CW    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CW-1:0]    num_vec,
    input  logic             stim_valid,
    input  logic [WIDTH-1:0] stim_a,
    input  logic [WIDTH-1:0] stim_b,
    input  logic             stim_cin,
    input  logic [WIDTH-1:0] rsp_sum,
    input  logic             rsp_cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             err,
    output logic [CW-1:0]    checked_cnt,
    output logic [CW-1:0]    err_cnt,
    output logic [WIDTH-1:0] first_err_a,
    output logic [WIDTH-1:0] first_err_b,
    output logic             first_err_cin,
    output logic [WIDTH-1:0] first_err_sum,
    output logic             first_err_cout
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    target;
    logic             dly_valid;
    logic [WIDTH-1:0] dly_a, dly_b;
    logic             dly_cin;
    logic [WIDTH:0]   exp_res;
    logic             mismatch;
    logic             strobe;

    // The beat arriving DLY cycles ago is the one the current response belongs to.
    generate
        if (DLY == 0) begin : g_nodly
            assign dly_valid = stim_valid;
            assign dly_a     = stim_a;
            assign dly_b     = stim_b;
            assign dly_cin   = stim_cin;
        end else begin : g_pipe
            logic [DLY-1:0]   vp;
            logic [DLY-1:0]   cp;
            logic [WIDTH-1:0] ap [DLY];
            logic [WIDTH-1:0] bp [DLY];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vp <= '0;
                    cp <= '0;
                    for (int i = 0; i < DLY; i++) begin
                        ap[i] <= '0;
                        bp[i] <= '0;
                    end
                end else begin
                    if (start) begin
                        vp <= '0;
                    end else begin
                        vp[0] <= stim_valid;
                        for (int i = 1; i < DLY; i++) vp[i] <= vp[i-1];
                    end
                    cp[0] <= stim_cin;
                    ap[0] <= stim_a;
                    bp[0] <= stim_b;
                    for (int i = 1; i < DLY; i++) begin
                        cp[i] <= cp[i-1];
                        ap[i] <= ap[i-1];
                        bp[i] <= bp[i-1];
                    end
                end
            end

            assign dly_valid = vp[DLY-1];
            assign dly_a     = ap[DLY-1];
            assign dly_b     = bp[DLY-1];
            assign dly_cin   = cp[DLY-1];
        end
    endgenerate

    assign exp_res  = {1'b0, dly_a} + {1'b0, dly_b} + {{WIDTH{1'b0}}, dly_cin};
    assign mismatch = ({rsp_cout, rsp_sum} != exp_res);
    assign strobe   = dly_valid && (state == RUN) && (checked_cnt < target) && !start;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                if (start)
                    state_nxt = RUN;
                else if (checked_cnt == target)
                    state_nxt = DONE;
`ifdef CHK_HALT_ON_ERR_EN
                else if (strobe && mismatch)
                    state_nxt = DONE;
`endif
            end
            DONE: if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // First-failure capture is gated by the sticky flag so later mismatches cannot overwrite it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target         <= '0;
            checked_cnt    <= '0;
            err_cnt        <= '0;
            err            <= 1'b0;
            first_err_a    <= '0;
            first_err_b    <= '0;
            first_err_cin  <= 1'b0;
            first_err_sum  <= '0;
            first_err_cout <= 1'b0;
        end else if (start) begin
            target         <= num_vec;
            checked_cnt    <= '0;
            err_cnt        <= '0;
            err            <= 1'b0;
            first_err_a    <= '0;
            first_err_b    <= '0;
            first_err_cin  <= 1'b0;
            first_err_sum  <= '0;
            first_err_cout <= 1'b0;
        end else if (strobe) begin
            checked_cnt <= checked_cnt + 1'b1;
            if (mismatch) begin
                if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
                err <= 1'b1;
                if (!err) begin
                    first_err_a    <= dly_a;
                    first_err_b    <= dly_b;
                    first_err_cin  <= dly_cin;
                    first_err_sum  <= rsp_sum;
                    first_err_cout <= rsp_cout;
                end
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign pass = done && (err_cnt == '0);

endmodule

// File: tb/tb_cla_result_checker.sv
// Bench for cla_result_checker: a DLY=0 and a DLY=2 instance driven by directed and random runs against a vector-list model.
module tb_cla_result_checker;

    localparam int W  = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start0 = 1'b0, start2 = 1'b0;
    logic [CW-1:0] num_vec = '0;
    logic          stim_valid = 1'b0;
    logic [W-1:0]  stim_a = '0, stim_b = '0;
    logic          stim_cin = 1'b0;
    logic [W-1:0]  rsp0_sum = '0, rsp2_sum = '0;
    logic          rsp0_cout = 1'b0, rsp2_cout = 1'b0;

    logic          busy0, done0, pass0, err0, fc0, fco0;
    logic [CW-1:0] cnt0, ecnt0;
    logic [W-1:0]  fa0, fb0, fs0;
    logic          busy2, done2, pass2, err2, fc2, fco2;
    logic [CW-1:0] cnt2, ecnt2;
    logic [W-1:0]  fa2, fb2, fs2;

    always #5 clk = ~clk;

    cla_result_checker #(.WIDTH(W), .DLY(0), .CW(CW)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .num_vec(num_vec),
        .stim_valid(stim_valid), .stim_a(stim_a), .stim_b(stim_b), .stim_cin(stim_cin),
        .rsp_sum(rsp0_sum), .rsp_cout(rsp0_cout),
        .busy(busy0), .done(done0), .pass(pass0), .err(err0),
        .checked_cnt(cnt0), .err_cnt(ecnt0),
        .first_err_a(fa0), .first_err_b(fb0), .first_err_cin(fc0),
        .first_err_sum(fs0), .first_err_cout(fco0)
    );

    cla_result_checker #(.WIDTH(W), .DLY(2), .CW(CW)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .num_vec(num_vec),
        .stim_valid(stim_valid), .stim_a(stim_a), .stim_b(stim_b), .stim_cin(stim_cin),
        .rsp_sum(rsp2_sum), .rsp_cout(rsp2_cout),
        .busy(busy2), .done(done2), .pass(pass2), .err(err2),
        .checked_cnt(cnt2), .err_cnt(ecnt2),
        .first_err_a(fa2), .first_err_b(fb2), .first_err_cin(fc2),
        .first_err_sum(fs2), .first_err_cout(fco2)
    );

    int         checks = 0;
    int         errors = 0;
    int         va [64];
    int         vb [64];
    int         vc [64];
    bit         vv [64];
    logic [W:0] rsp [64];
    int         trace [64];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearVecs();
        for (int i = 0; i < 64; i++) begin
            vv[i] = 1'b0; va[i] = 0; vb[i] = 0; vc[i] = 0; rsp[i] = '0;
        end
    endtask

    // Correct response is the plain integer sum; a bad one flips at least one of its five bits.
    task automatic setVec(input int i, input int a, input int b, input int c, input bit good);
        int s;
        s = a + b + c;
        va[i] = a; vb[i] = b; vc[i] = c; vv[i] = 1'b1;
        rsp[i] = good ? 5'(s) : 5'(s ^ (1 + $urandom_range(0, 30)));
    endtask

    task automatic startRun(input bit sel, input int n);
        num_vec = CW'(n);
        if (sel) start2 = 1'b1; else start0 = 1'b1;
        step();
        start0 = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic applyStimulus(input bit sel, input int ncyc, input int shift);
        for (int c = 0; c < ncyc + (sel ? 2 : 0); c++) begin
            int idx;
            if (c < ncyc) begin
                stim_valid = vv[c];
                stim_a     = va[c][W-1:0];
                stim_b     = vb[c][W-1:0];
                stim_cin   = vc[c][0];
                {rsp0_cout, rsp0_sum} = rsp[c];
            end else begin
                stim_valid = 1'b0;
                {rsp0_cout, rsp0_sum} = '0;
            end
            idx = c - shift;
            if (idx >= 0 && idx < ncyc) {rsp2_cout, rsp2_sum} = rsp[idx];
            else                        {rsp2_cout, rsp2_sum} = '0;
            step();
            trace[c] = sel ? int'(cnt2) : int'(cnt0);
        end
        stim_valid = 1'b0;
    endtask

    // Model: walk the valid beats in order; only the first target of them are judged.
    task automatic checkRun(input string tag, input int ncyc, input int target);
        int ec, ee, fi;
        ec = 0; ee = 0; fi = -1;
        for (int c = 0; c < ncyc; c++) begin
            if (vv[c] && ec < target) begin
                ec++;
                if (int'(rsp[c]) != va[c] + vb[c] + vc[c]) begin
                    ee++;
                    if (fi < 0) fi = c;
                end
            end
        end
        checkOutput({tag, "_checked"}, 32'(cnt0), 32'(ec));
        checkOutput({tag, "_errcnt"},  32'(ecnt0), 32'(ee));
        checkOutput({tag, "_err"},     32'(err0), 32'(ee > 0));
        if (fi >= 0) begin
            checkOutput({tag, "_fa"},    32'(fa0),  32'(va[fi]));
            checkOutput({tag, "_fb"},    32'(fb0),  32'(vb[fi]));
            checkOutput({tag, "_fcin"},  32'(fc0),  32'(vc[fi]));
            checkOutput({tag, "_fsum"},  32'(fs0),  32'(rsp[fi][W-1:0]));
            checkOutput({tag, "_fcout"}, 32'(fco0), 32'(rsp[fi][W]));
        end
        step();
        step();
        checkOutput({tag, "_done"}, 32'(done0), 32'(ec == target));
        checkOutput({tag, "_pass"}, 32'(pass0), 32'(ec == target && ee == 0));
    endtask

    initial begin
        int n, t;
        clearVecs();
        step();
        step();
        checkOutput("rst_busy", 32'(busy0), 0);
        checkOutput("rst_done", 32'(done0), 0);
        checkOutput("rst_pass", 32'(pass0), 0);
        checkOutput("rst_cnt",  32'(cnt0),  0);
        checkOutput("rst_done2", 32'(done2), 0);
        #3 rst_n = 1'b1;
        step();

        // Beats without a start are ignored.
        setVec(0, 1, 2, 0, 1'b1);
        setVec(1, 3, 3, 1, 1'b0);
        applyStimulus(1'b0, 2, 0);
        checkOutput("idle_cnt",  32'(cnt0), 0);
        checkOutput("idle_busy", 32'(busy0), 0);

        clearVecs();
        setVec(0, 0, 0, 0, 1'b1);
        setVec(1, 2, 6, 1, 1'b1);
        setVec(2, 15, 13, 0, 1'b1);
        setVec(3, 10, 5, 0, 1'b1);
        startRun(1'b0, 4);
        applyStimulus(1'b0, 4, 0);
        checkOutput("t1_cnt",    32'(cnt0), 4);
        checkOutput("t1_busy",   32'(busy0), 1);
        checkOutput("t1_early",  32'(done0), 0);
        step();
        checkOutput("t1_done",   32'(done0), 1);
        checkOutput("t1_pass",   32'(pass0), 1);

        setVec(4, 3, 12, 1, 1'b1);
        rsp[2] = 5'b0_1100;
        rsp[4] = 5'b0_0000;
        startRun(1'b0, 5);
        applyStimulus(1'b0, 5, 0);
        checkOutput("t2_errcnt2", 32'(ecnt0), 2);
        checkOutput("t2_fa15",    32'(fa0), 15);
        checkRun("t2", 5, 5);

        clearVecs();
        for (int i = 0; i < 5; i++) setVec(i, i, 2 * i, i % 2, 1'b1);
        startRun(1'b0, 2);
        applyStimulus(1'b0, 5, 0);
        checkRun("t4", 5, 2);

        startRun(1'b0, 0);
        checkOutput("t4z_busy", 32'(busy0), 1);
        checkOutput("t4z_early", 32'(done0), 0);
        step();
        checkOutput("t4z_done", 32'(done0), 1);
        checkOutput("t4z_pass", 32'(pass0), 1);

        clearVecs();
        for (int i = 0; i < 6; i++) setVec(i, i + 1, i + 1, 0, 1'b1);
        startRun(1'b1, 6);
        applyStimulus(1'b1, 6, 2);
        for (int c = 0; c < 8; c++)
            checkOutput($sformatf("t3_trace%0d", c), 32'(trace[c]), 32'((c < 2) ? 0 : c - 1));
        step();
        checkOutput("t3_done", 32'(done2), 1);
        checkOutput("t3_pass", 32'(pass2), 1);
        startRun(1'b1, 6);
        applyStimulus(1'b1, 6, 1);
        step();
        checkOutput("t3_misalign", 32'(ecnt2 != '0), 1);
        checkOutput("t3_mis_pass", 32'(pass2), 0);

        clearVecs();
        for (int i = 0; i < 6; i++) setVec(i, 5, i, 1, 1'b1);
        startRun(1'b0, 6);
        applyStimulus(1'b0, 3, 0);
        checkOutput("t5_pre", 32'(cnt0), 3);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t5_busy", 32'(busy0), 0);
        checkOutput("t5_cnt",  32'(cnt0), 0);
        checkOutput("t5_cnt2", 32'(cnt2), 0);
        checkOutput("t5_err2", 32'(err2), 0);
        #1 rst_n = 1'b1;
        step();
        startRun(1'b0, 6);
        applyStimulus(1'b0, 6, 0);
        checkRun("t5_rerun", 6, 6);

        for (int r = 0; r < 6; r++) begin
            clearVecs();
            n = $urandom_range(4, 20);
            t = $urandom_range(1, n + 2);
            for (int i = 0; i < n; i++) begin
                setVec(i, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1),
                       $urandom_range(0, 3) != 0);
                vv[i] = ($urandom_range(0, 3) != 0);
            end
            startRun(1'b0, t);
            applyStimulus(1'b0, n, 0);
            checkRun($sformatf("rnd%0d", r), n, t);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cla_result_checker.md
Name: cla_result_checker

Overview:
Response-side companion to the 4-bit carry-look-ahead adder stimulus stream. It takes the vectors driven into the adder (a, b, cin) and the adder's returned sum/Cout, aligns them through a configurable delay line, and compares them against a golden a+b+cin. It counts checked vectors and errors, captures the first failing vector and reports pass/fail when a programmed vector count is reached. It sits in the synthesizable self-check harness next to the adder, on the same clock.

Parameters:
WIDTH, 4, operand width of a, b and sum
DLY, 0, cycles between a stimulus beat and its response (0 = response in the same cycle)
CW, 8, width of the vector target and counters

Ports:
clk  input  1  clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse: clear state and begin a check run
num_vec  input  CW  number of vectors to check, sampled on start
stim_valid  input  1  stimulus beat valid
stim_a  input  WIDTH  operand a
stim_b  input  WIDTH  operand b
stim_cin  input  1  carry in
rsp_sum  input  WIDTH  adder sum, belongs to the stimulus DLY cycles earlier
rsp_cout  input  1  adder Cout, same alignment as rsp_sum
busy  output  1  high in RUN
done  output  1  high in DONE
pass  output  1  done && err_cnt==0
err  output  1  sticky: at least one mismatch this run
checked_cnt  output  CW  vectors compared this run
err_cnt  output  CW  mismatches this run, saturates at all-ones
first_err_a, first_err_b  output  WIDTH  operands of the first failing vector
first_err_cin  output  1  cin of the first failing vector
first_err_sum  output  WIDTH  observed sum of the first failing vector
first_err_cout  output  1  observed Cout of the first failing vector

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE; all outputs, counters, first_err_* and delay-line valids = 0.
- FSM states IDLE, RUN, DONE.
  - IDLE: ignores stim_valid. start -> RUN.
  - RUN: start -> RUN with a full clear (restart). Otherwise stays in RUN until checked_cnt==target, then -> DONE.
  - DONE: holds all results and ignores stim_valid. start -> RUN with a full clear.
- Start clear: on the start cycle, latch target=num_vec; zero counters, err, first_err_* and delay-line valids.
- num_vec==0: start goes to RUN, then to DONE on the next cycle; pass=1.
- Alignment: a shift register of depth DLY carries {valid,a,b,cin}. The compare strobe is the delayed valid, qualified by state==RUN and checked_cnt<target. With DLY=0 the strobe is stim_valid itself.
- Golden result: exp = a + b + cin, computed at WIDTH+1 bits, zero-extended. Mismatch = {rsp_cout,rsp_sum} != exp.
- Compare is registered:
  - checked_cnt, err_cnt, err and first_err_* update on the clock edge ending the strobe cycle, i.e. one cycle after the response is presented.
  - done asserts the cycle after the last count update.
- first_err_* capture only when err was 0 before the mismatch. Later mismatches never overwrite them.
- err_cnt stops at all-ones. checked_cnt cannot exceed target.
- Strobes after the target is reached, and beats still in the pipe at DONE, are dropped.
- Reset mid-run aborts immediately to IDLE with everything cleared.
- Back-to-back stim_valid every cycle is supported, with no stalls.

Optional Feature:
CHK_HALT_ON_ERR_EN
- Defined: the first mismatch forces RUN -> DONE on the next edge. checked_cnt includes the failing vector, err_cnt=1, pass=0.
- Undefined: a run always continues until checked_cnt==target.

Test Plan:
1. DLY=0, start with num_vec=4; vectors (0,0,0), (2,6,1), (15,13,0), (10,5,0) with correct responses 0/0, 9/0, 12/1, 15/0 -> done one cycle after the 4th compare, checked_cnt=4, err_cnt=0, pass=1.
2. Same vectors, but (15,13,0) returns sum=12, cout=0 -> err_cnt=1, err=1, pass=0, first_err = a=15, b=13, cin=0, sum=12, cout=0. A second bad vector (3,12,1) returning 0/0 leaves first_err unchanged and gives err_cnt=2.
3. DLY=2, 6 back-to-back beats with responses delayed 2 cycles -> 6 compares on consecutive cycles, pass=1. Responses misaligned by 1 cycle -> err_cnt>0.
4. num_vec=2 with 5 valid beats -> checked_cnt stays 2, done=1, the extra beats have no effect. num_vec=0 -> done the cycle after RUN entry, pass=1.
5. Pull rst_n low mid-run after 3 compares -> all outputs 0 immediately. A new start re-runs cleanly; start asserted in DONE clears the previous errors.
6. With CHK_HALT_ON_ERR_EN defined and the 2nd of 4 vectors wrong -> DONE with checked_cnt=2, err_cnt=1, pass=0; further beats are ignored.
